// File: rtl/procesor_pkg.sv
// Shared sequencer state encodings and opcode constants for the processor slice.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package procesor_pkg;

  typedef enum logic [5:0] {
    ST_FETCH1 = 6'd1,
    ST_FETCH2 = 6'd2,
    ST_FETCH3 = 6'd3,
    ST_FETCH4 = 6'd4,
    ST_DECODE = 6'd5,
    ST_JMP    = 6'd21,
    ST_JZ     = 6'd22,
    ST_JNZ    = 6'd23,
    ST_PCINC  = 6'd32
  } state_t;

  // Legal opcodes, named by their hex value; 0x30..0x37 form one group.
  localparam logic [5:0] OPC_00 = 6'b000000;
  localparam logic [5:0] OPC_09 = 6'b001001;
  localparam logic [5:0] OPC_10 = 6'b010000;
  localparam logic [5:0] OPC_11 = 6'b010001;
  localparam logic [5:0] OPC_20 = 6'b100000;
  localparam logic [5:0] OPC_21 = 6'b100001;
  localparam logic [5:0] OPC_24 = 6'b100100;
  localparam logic [5:0] OPC_26 = 6'b100110;
  localparam logic [5:0] OPC_38 = 6'b111000;
  localparam logic [5:0] OPC_39 = 6'b111001;
  localparam logic [5:0] OPC_3C = 6'b111100;
  localparam logic [5:0] OPC_3D = 6'b111101;
  localparam logic [5:0] OPC_3F = 6'b111111;

  // True in the four byte-fetch states.
  function automatic logic is_fetch(input logic [5:0] s);
    return (s >= ST_FETCH1) && (s <= ST_FETCH4);
  endfunction

  // True in the three jump states (the condition itself is resolved by the sequencer).
  function automatic logic is_jump(input logic [5:0] s);
    return (s == ST_JMP) || (s == ST_JZ) || (s == ST_JNZ);
  endfunction

  // True for every opcode the core implements.
  function automatic logic op_legal(input logic [5:0] o);
    logic ok;
    ok = 1'b0;
    if (o[5:3] == 3'b110) ok = 1'b1;
    case (o)
      OPC_00, OPC_09, OPC_10, OPC_11, OPC_20, OPC_21, OPC_24,
      OPC_26, OPC_38, OPC_39, OPC_3C, OPC_3D, OPC_3F: ok = 1'b1;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and the memory.
// Latency: read data returns exactly one cycle after mem_rd.
// Backpressure: none; the memory always answers in one cycle.
interface fetch_unit_if #(parameter int ADDR_W = 16);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/pc_reg.sv
// Program counter: increments during fetch, loads the jump target in jump states.
// Latency: new value visible one cycle after the qualifying edge.
// Backpressure: none; the sequencer state fully determines the update.
module pc_reg
  import procesor_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        state,
  input  logic [15:0]       jump_target,
  output logic [ADDR_W-1:0] pc
);

  // Advance (with natural wrap) per fetched byte, or load the target on a jump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (is_fetch(state)) begin
      pc <= pc + ADDR_W'(1);
    end else if (is_jump(state)) begin
      pc <= ADDR_W'(jump_target);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads four bytes into ir, tracks pc and the zero flag.
// Latency: each byte lands in ir one edge after its FETCHk request.
// Backpressure: none; optional illegal-opcode trap under ILLEGAL_OP_TRAP_EN.
module fetch_unit
  import procesor_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        state,
  fetch_unit_if.master      mem,
  input  logic [15:0]       alu_result,
  input  logic              alu_wr,
  output logic [31:0]       ir,
  output logic [5:0]        op,
  output logic [2:0]        funct,
  output logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic              trap
);

  logic       pend_vld;
  logic [1:0] pend_idx;

  assign mem.mem_rd   = is_fetch(state);
  assign mem.mem_addr = pc;
  assign op           = ir[31:26];
  assign funct        = ir[23:21];

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .jump_target (ir[15:0]),
    .pc          (pc)
  );

  // One-deep pending tracker: a request issued now retires on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_idx <= 2'd0;
    end else begin
      pend_vld <= is_fetch(state);
      pend_idx <= state[1:0] - 2'd1;
    end
  end

  // Retiring entry writes its byte; other bytes hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (pend_vld) begin
      case (pend_idx)
        2'd0:    ir[31:24] <= mem.mem_rdata;
        2'd1:    ir[23:16] <= mem.mem_rdata;
        2'd2:    ir[15:8]  <= mem.mem_rdata;
        default: ir[7:0]   <= mem.mem_rdata;
      endcase
    end
  end

  // Zero flag follows the ALU only when its result is written back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero <= 1'b0;
    end else if (alu_wr) begin
      zero <= (alu_result == 16'h0000);
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  // Sticky trap: set when an unimplemented opcode is decoded, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap <= 1'b0;
    end else if ((state == ST_DECODE) && !op_legal(op)) begin
      trap <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random state streams.
// Outputs are compared each cycle against a byte-level behavioural model.
// Build with ILLEGAL_OP_TRAP_EN defined to also exercise the trap.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  state;
  logic [15:0] alu_result;
  logic        alu_wr;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [2:0]  funct;
  logic        zero;
  logic [15:0] pc;
  logic        trap;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:65535];

  // Model state
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_zero;
  logic        m_trap;
  int          pend_q[$];   // entries: byte_index*65536 + address

  fetch_unit_if #(.ADDR_W(16)) mif ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .mem        (mif),
    .alu_result (alu_result),
    .alu_wr     (alu_wr),
    .ir         (ir),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pc         (pc),
    .trap       (trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers one cycle after a read strobe.
  always @(posedge clk) begin
    if (mif.mem_rd) mif.mem_rdata <= mem[mif.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_op(input int o);
    return (o inside {0, 9, 16, 17, 32, 33, 36, 38, 56, 57, 60, 61, 63}) || (o >= 48 && o <= 55);
  endfunction

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_ir   = 32'h0;
    m_zero = 1'b0;
    m_trap = 1'b0;
    pend_q.delete();
  endtask

  // One clock edge of the reference behaviour, using pre-edge values.
  task automatic model_edge(input int st, input logic aw, input logic [15:0] ar);
    logic [31:0] nir;
    logic [15:0] npc;
    int e, idx, addr;
    nir = m_ir;
    npc = m_pc;
    if (pend_q.size() > 0) begin
      e    = pend_q.pop_front();
      idx  = e / 65536;
      addr = e % 65536;
      nir[31 - 8*idx -: 8] = mem[addr];
    end
    if (st >= 1 && st <= 4) begin
      pend_q.push_back((st - 1) * 65536 + int'(m_pc));
      npc = m_pc + 16'd1;
    end else if (st == 21 || st == 22 || st == 23) begin
      npc = m_ir[15:0];
    end
    if (aw) m_zero = (ar == 16'h0);
`ifdef ILLEGAL_OP_TRAP_EN
    if (st == 5 && !legal_op(int'(m_ir[31:26]))) m_trap = 1'b1;
`endif
    m_ir = nir;
    m_pc = npc;
  endtask

  task automatic compare_outputs();
    check("ir", ir, m_ir);
    check("op", 32'(op), 32'(m_ir[31:26]));
    check("funct", 32'(funct), 32'(m_ir[23:21]));
    check("pc", 32'(pc), 32'(m_pc));
    check("zero", 32'(zero), 32'(m_zero));
    check("trap", 32'(trap), 32'(m_trap));
  endtask

  // Drive one cycle, check strobe/address before the edge and all outputs after.
  task automatic tick(input int st, input logic aw = 1'b0, input logic [15:0] ar = 16'h0);
    state      = 6'(st);
    alu_wr     = aw;
    alu_result = ar;
    #1;
    check("mem_rd", 32'(mif.mem_rd), 32'(st >= 1 && st <= 4));
    check("mem_addr", 32'(mif.mem_addr), 32'(m_pc));
    @(posedge clk);
    model_edge(st, aw, ar);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    state  = 6'd0;
    alu_wr = 1'b0;
    reset  = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(posedge clk);
    #1;
    compare_outputs();
    reset = 1'b0;
  endtask

  // Fetch a legal instruction whose low half is target, then jump to it.
  task automatic load_pc(input logic [15:0] target);
    mem[m_pc]         = 8'h00;
    mem[m_pc + 16'd1] = 8'h00;
    mem[m_pc + 16'd2] = target[15:8];
    mem[m_pc + 16'd3] = target[7:0];
    for (int k = 1; k <= 5; k++) tick(k);
    tick(21);
  endtask

  initial begin
    logic [15:0] wrap_addr [4];
    int choice;
    int st_tab [10];
    wrap_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    st_tab    = '{0, 1, 2, 3, 4, 5, 21, 22, 23, 32};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    reset = 1'b1; state = 6'd0; alu_wr = 1'b0; alu_result = 16'h0;
    model_reset();
    #1;
    compare_outputs();
    check("rst_pc", 32'(pc), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic four-byte fetch and decode.
    mem[0] = 8'hA4; mem[1] = 8'hE0; mem[2] = 8'h00; mem[3] = 8'h10;
    for (int k = 1; k <= 4; k++) tick(k);
    check("dec_op", 32'(op), 32'(6'b101001));
    check("dec_funct", 32'(funct), 32'(3'b111));
    tick(5);
    check("dec_ir", ir, 32'hA4E00010);
    check("dec_pc", 32'(pc), 32'h4);

    // Zero flag update and hold.
    tick(0, 1'b1, 16'h0000);
    check("zero_set", 32'(zero), 32'h1);
    tick(0, 1'b1, 16'h8000);
    check("zero_clr", 32'(zero), 32'h0);
    tick(0, 1'b0, 16'h0000);
    check("zero_hold", 32'(zero), 32'h0);

    // Jump load, then PCINC holds.
    load_pc(16'h0008);
    check("jmp_pc8", 32'(pc), 32'h0008);
    load_pc(16'h0123);
    check("jmp_pc", 32'(pc), 32'h0123);
    tick(32);
    check("pcinc_hold", 32'(pc), 32'h0123);

    // Jump and flag update on the same edge.
    tick(22, 1'b1, 16'h0000);
    check("jz_flag", 32'(zero), 32'h1);

    // Address wrap during fetch.
    load_pc(16'hFFFE);
    check("wrap_start", 32'(pc), 32'hFFFE);
    for (int k = 0; k < 4; k++) begin
      state = 6'(k + 1);
      #1;
      check("wrap_addr", 32'(mif.mem_addr), 32'(wrap_addr[k]));
      tick(k + 1);
    end
    check("wrap_pc", 32'(pc), 32'h0002);
    tick(5);

    // Reset in the middle of a fetch with 0xFF on the bus.
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    tick(1);
    tick(2);
    state = 6'd3;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_ir", ir, 32'h0);
    check("midrst_pc", 32'(pc), 32'h0);
    @(posedge clk);
    #1;
    state = 6'd0;
    reset = 1'b0;
    tick(0);
    tick(0);
    check("postrst_ir", ir, 32'h0);

`ifdef ILLEGAL_OP_TRAP_EN
    // Illegal opcode sets a sticky trap.
    do_reset();
    mem[0] = 8'h08;
    for (int k = 1; k <= 5; k++) tick(k);
    check("trap_set", 32'(trap), 32'h1);
    mem[4] = 8'h00;
    for (int k = 1; k <= 5; k++) tick(k);
    check("trap_sticky", 32'(trap), 32'h1);
`endif

    // Random state streams against the model.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      choice = $urandom_range(0, 9);
      if (choice < 4) begin
        for (int k = 1; k <= 5; k++)
          tick(k, 1'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      end else if (choice == 9 && $urandom_range(0, 4) == 0) begin
        do_reset();
      end else begin
        for (int j = 0; j < 3; j++) begin
          if ($urandom_range(0, 7) == 0)
            tick($urandom_range(0, 63), 1'($urandom), 16'($urandom));
          else
            tick(st_tab[$urandom_range(0, 9)], 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
